// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port,
// with a registered write stage and a busy scoreboard for issue stalls.
module regfile_wb_arbiter #(
    parameter bit ZERO_REG_WRITABLE = 1'b1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [3:0]       req0_addr,
    input  logic [15:0]      req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_addr,
    input  logic [15:0]      req1_data,
    output logic             req1_ready,
    input  logic             mark_en,
    input  logic [3:0]       mark_addr,
    output logic             rf_w_en,
    output logic [3:0]       rf_addr_c,
    output logic [15:0]      rf_data_c,
    output logic [15:0]      busy,
    output logic             last_grant,
    output logic [CNT_W-1:0] wb_count
);

    // Handshake: a write transfers when valid & ready are both high at a rising
    // edge. Ready is combinational from both valids and last_grant; a requester
    // must not make its valid depend on its ready.
    logic             w_grant0;
    logic             w_grant1;
    logic             w_xfer;
    logic [3:0]       w_addr;
    logic [15:0]      w_data;
    logic             w_issue;
    logic             w_mark;
    logic [15:0]      w_busy_next;

    logic             r_rf_w_en;
    logic [3:0]       r_rf_addr_c;
    logic [15:0]      r_rf_data_c;
    logic [15:0]      r_busy;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_wb_count;

    assign w_grant0 = !rst && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = !rst && req1_valid && (!req0_valid || !r_last_grant);
    assign w_xfer   = w_grant0 || w_grant1;
    assign w_addr   = w_grant1 ? req1_addr : req0_addr;
    assign w_data   = w_grant1 ? req1_data : req0_data;

    // Register 0 may be hard-wired: accept the handshake but never write it.
    assign w_issue  = w_xfer && (ZERO_REG_WRITABLE || (w_addr != 4'd0));
    assign w_mark   = mark_en && (ZERO_REG_WRITABLE || (mark_addr != 4'd0));

    // Clear first, then mark, so a same-register mark overrides the clear.
    always_comb begin
        w_busy_next = r_busy;
        if (w_xfer) begin
            w_busy_next[w_addr] = 1'b0;
        end
        if (w_mark) begin
            w_busy_next[mark_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_w_en    <= 1'b0;
            r_rf_addr_c  <= 4'd0;
            r_rf_data_c  <= 16'd0;
            r_busy       <= 16'd0;
            r_last_grant <= 1'b1;
            r_wb_count   <= '0;
        end else begin
            r_rf_w_en <= w_issue;
            if (w_issue) begin
                r_rf_addr_c <= w_addr;
                r_rf_data_c <= w_data;
            end
            if (w_xfer) begin
                r_last_grant <= w_grant1;
                r_wb_count   <= r_wb_count + 1'b1;
            end
            r_busy <= w_busy_next;
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rf_w_en    = r_rf_w_en;
    assign rf_addr_c  = r_rf_addr_c;
    assign rf_data_c  = r_rf_data_c;
    assign busy       = r_busy;
    assign last_grant = r_last_grant;
    assign wb_count   = r_wb_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: one default instance plus one with register 0 hard-wired
// and a 2-bit counter, both fed the same stimulus.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, mark_en;
    logic [3:0]  req0_addr, req1_addr, mark_addr;
    logic [15:0] req0_data, req1_data;

    logic        a_r0_rdy, a_r1_rdy, a_wen, a_lg;
    logic [3:0]  a_addr;
    logic [15:0] a_data, a_busy, a_cnt;

    logic        z_r0_rdy, z_r1_rdy, z_wen, z_lg;
    logic [3:0]  z_addr;
    logic [15:0] z_data, z_busy;
    logic [1:0]  z_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(a_r0_rdy),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(a_r1_rdy),
        .mark_en(mark_en), .mark_addr(mark_addr),
        .rf_w_en(a_wen), .rf_addr_c(a_addr), .rf_data_c(a_data),
        .busy(a_busy), .last_grant(a_lg), .wb_count(a_cnt)
    );

    regfile_wb_arbiter #(.ZERO_REG_WRITABLE(1'b0), .CNT_W(2)) dut_z (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(z_r0_rdy),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(z_r1_rdy),
        .mark_en(mark_en), .mark_addr(mark_addr),
        .rf_w_en(z_wen), .rf_addr_c(z_addr), .rf_data_c(z_data),
        .busy(z_busy), .last_grant(z_lg), .wb_count(z_cnt)
    );

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; mark_en = 0;
        req0_addr = 0; req1_addr = 0; mark_addr = 0;
        req0_data = 0; req1_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        req0_valid = 1; req1_valid = 1;
        #1;
        tests_run++; if ({a_r0_rdy, a_r1_rdy} !== 2'b00) begin tests_failed++; $display("FAIL reset_ready_async: got %b expected 00", {a_r0_rdy, a_r1_rdy}); end
        tick();
        tick();
        tests_run++; if ({a_r0_rdy, a_r1_rdy, z_r0_rdy, z_r1_rdy} !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0000", {a_r0_rdy, a_r1_rdy, z_r0_rdy, z_r1_rdy}); end
        rst = 0;
        idle_inputs();
        exp_cnt = 0;
        #1;
        tests_run++; if ({a_wen, a_addr, a_data} !== 21'd0) begin tests_failed++; $display("FAIL reset_wport: got %h expected 0", {a_wen, a_addr, a_data}); end
        tests_run++; if (a_busy !== 16'h0000) begin tests_failed++; $display("FAIL reset_busy: got %h expected 0000", a_busy); end
        tests_run++; if (a_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", a_cnt); end
        tests_run++; if (a_lg !== 1'b1) begin tests_failed++; $display("FAIL reset_last_grant: got %b expected 1", a_lg); end
        tick();
        tests_run++; if ({a_r0_rdy, a_r1_rdy, a_wen} !== 3'b000) begin tests_failed++; $display("FAIL idle_outputs: got %b expected 000", {a_r0_rdy, a_r1_rdy, a_wen}); end
    endtask

    task automatic test_single_write();
        req0_valid = 1; req0_addr = 4'd5; req0_data = 16'hBEEF;
        #1;
        tests_run++; if ({a_r0_rdy, a_r1_rdy} !== 2'b10) begin tests_failed++; $display("FAIL single_ready: got %b expected 10", {a_r0_rdy, a_r1_rdy}); end
        tick();
        idle_inputs();
        exp_cnt++;
        tests_run++; if ({a_wen, a_addr, a_data} !== {1'b1, 4'd5, 16'hBEEF}) begin tests_failed++; $display("FAIL single_write: got %h expected %h", {a_wen, a_addr, a_data}, {1'b1, 4'd5, 16'hBEEF}); end
        tests_run++; if (a_lg !== 1'b0) begin tests_failed++; $display("FAIL single_last_grant: got %b expected 0", a_lg); end
        tick();
        tests_run++; if ({a_wen, a_addr, a_data} !== {1'b0, 4'd5, 16'hBEEF}) begin tests_failed++; $display("FAIL single_hold: got %h expected %h", {a_wen, a_addr, a_data}, {1'b0, 4'd5, 16'hBEEF}); end
        tests_run++; if (a_cnt !== 16'd1) begin tests_failed++; $display("FAIL single_count: got %0d expected 1", a_cnt); end
    endtask

    task automatic test_contention();
        do_reset();
        req0_valid = 1; req0_addr = 4'd1; req0_data = 16'h0001;
        req1_valid = 1; req1_addr = 4'd2; req1_data = 16'h0002;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++; if ({a_r0_rdy, a_r1_rdy} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin tests_failed++; $display("FAIL contention_grant%0d: got %b expected %b", i, {a_r0_rdy, a_r1_rdy}, (i % 2 == 0) ? 2'b10 : 2'b01); end
            tick();
            exp_cnt++;
            tests_run++; if ({a_wen, a_addr, a_data} !== {1'b1, (i % 2 == 0) ? 4'd1 : 4'd2, (i % 2 == 0) ? 16'h0001 : 16'h0002}) begin tests_failed++; $display("FAIL contention_write%0d: got %h", i, {a_wen, a_addr, a_data}); end
        end
        idle_inputs();
        tests_run++; if (a_cnt !== 16'd4) begin tests_failed++; $display("FAIL contention_count: got %0d expected 4", a_cnt); end
        tests_run++; if (z_cnt !== 2'd0) begin tests_failed++; $display("FAIL contention_wrap: got %0d expected 0", z_cnt); end
        tick();
        tests_run++; if (a_wen !== 1'b0) begin tests_failed++; $display("FAIL contention_idle: got %b expected 0", a_wen); end
    endtask

    task automatic test_scoreboard();
        mark_en = 1; mark_addr = 4'd7;
        tick();
        mark_en = 0;
        tests_run++; if (a_busy !== 16'h0080) begin tests_failed++; $display("FAIL sb_mark: got %h expected 0080", a_busy); end
        req1_valid = 1; req1_addr = 4'd7; req1_data = 16'h1234;
        mark_en = 1; mark_addr = 4'd7;
        #1;
        tests_run++; if ({a_r0_rdy, a_r1_rdy} !== 2'b01) begin tests_failed++; $display("FAIL sb_req1_ready: got %b expected 01", {a_r0_rdy, a_r1_rdy}); end
        tick();
        exp_cnt++;
        idle_inputs();
        tests_run++; if (a_busy !== 16'h0080) begin tests_failed++; $display("FAIL sb_mark_wins: got %h expected 0080", a_busy); end
        req1_valid = 1; req1_addr = 4'd7; req1_data = 16'h5678;
        tick();
        exp_cnt++;
        idle_inputs();
        tests_run++; if (a_busy !== 16'h0000) begin tests_failed++; $display("FAIL sb_clear: got %h expected 0000", a_busy); end
        tests_run++; if ({a_addr, a_data} !== {4'd7, 16'h5678}) begin tests_failed++; $display("FAIL sb_write: got %h expected 75678", {a_addr, a_data}); end
        mark_en = 1; mark_addr = 4'd7;
        tick();
        req0_valid = 1; req0_addr = 4'd7; req0_data = 16'h0777;
        mark_addr = 4'd3;
        tick();
        exp_cnt++;
        idle_inputs();
        tests_run++; if (a_busy !== 16'h0008) begin tests_failed++; $display("FAIL sb_mark_and_clear: got %h expected 0008", a_busy); end
        req0_valid = 1; req0_addr = 4'd3; req0_data = 16'h0333;
        tick();
        exp_cnt++;
        idle_inputs();
        tests_run++; if (a_busy !== 16'h0000) begin tests_failed++; $display("FAIL sb_clear3: got %h expected 0000", a_busy); end
    endtask

    task automatic test_zero_reg();
        mark_en = 1; mark_addr = 4'd0;
        tick();
        idle_inputs();
        tests_run++; if (z_busy !== 16'h0000) begin tests_failed++; $display("FAIL zero_mark_ignored: got %h expected 0000", z_busy); end
        tests_run++; if (a_busy !== 16'h0001) begin tests_failed++; $display("FAIL zero_mark_writable: got %h expected 0001", a_busy); end
        req0_valid = 1; req0_addr = 4'd0; req0_data = 16'hAAAA;
        #1;
        tests_run++; if (z_r0_rdy !== 1'b1) begin tests_failed++; $display("FAIL zero_ready: got %b expected 1", z_r0_rdy); end
        tick();
        exp_cnt++;
        idle_inputs();
        tests_run++; if (z_wen !== 1'b0) begin tests_failed++; $display("FAIL zero_no_write: got %b expected 0", z_wen); end
        tests_run++; if ({a_wen, a_addr, a_data} !== {1'b1, 4'd0, 16'hAAAA}) begin tests_failed++; $display("FAIL zero_write_writable: got %h", {a_wen, a_addr, a_data}); end
        tests_run++; if (a_cnt !== 16'(exp_cnt)) begin tests_failed++; $display("FAIL zero_count: got %0d expected %0d", a_cnt, exp_cnt); end
        tests_run++; if (z_cnt !== 2'(exp_cnt)) begin tests_failed++; $display("FAIL zero_count_z: got %0d expected %0d", z_cnt, exp_cnt % 4); end
        tests_run++; if (a_busy !== 16'h0000) begin tests_failed++; $display("FAIL zero_clear: got %h expected 0000", a_busy); end
    endtask

    task automatic test_reset_mid();
        req0_valid = 1; req0_addr = 4'd9; req0_data = 16'h5555;
        mark_en = 1; mark_addr = 4'd4;
        tick();
        idle_inputs();
        tests_run++; if (a_wen !== 1'b1 || a_busy !== 16'h0010) begin tests_failed++; $display("FAIL mid_pre: got wen=%b busy=%h expected 1/0010", a_wen, a_busy); end
        req0_valid = 1; req0_addr = 4'd9;
        rst = 1;
        tick();
        idle_inputs();
        tests_run++; if ({a_wen, a_addr, a_data} !== 21'd0) begin tests_failed++; $display("FAIL mid_dropped: got %h expected 0", {a_wen, a_addr, a_data}); end
        tests_run++; if (a_busy !== 16'h0000 || a_cnt !== 16'd0 || a_lg !== 1'b1) begin tests_failed++; $display("FAIL mid_state: got busy=%h cnt=%0d lg=%b expected 0/0/1", a_busy, a_cnt, a_lg); end
        rst = 0;
        exp_cnt = 0;
    endtask

    task automatic test_back_to_back();
        req1_valid = 1; req1_addr = 4'd2;
        for (int i = 0; i < 4; i++) begin
            req1_data = 16'(16'hC000 + i);
            tick();
            exp_cnt++;
            tests_run++; if ({a_wen, a_data} !== {1'b1, 16'(16'hC000 + i)}) begin tests_failed++; $display("FAIL b2b_write%0d: got %h", i, {a_wen, a_data}); end
            tests_run++; if (z_cnt !== 2'((i + 1) % 4)) begin tests_failed++; $display("FAIL b2b_wrap%0d: got %0d expected %0d", i, z_cnt, (i + 1) % 4); end
        end
        idle_inputs();
        tests_run++; if (a_cnt !== 16'd4) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 4", a_cnt); end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_contention();
        test_scoreboard();
        test_zero_reg();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (w_en, addr_c, data_c) between two writeback requesters: req0 (ALU result) and req1 (memory load).
- Uses round-robin arbitration with valid/ready handshakes and a registered write stage.
- Maintains a 16-entry busy scoreboard so the decode/issue logic can stall on pending destination registers.
- Sits between the execute/memory stages and the 16x16-bit register file.

Parameters:
- ZERO_REG_WRITABLE, 1, when 0 writes to register 0 are accepted but never issued to the file, and busy[0] is never set.
- CNT_W, 16, width of the accepted-write counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a write pending
- req0_addr  input  4  requester 0 destination register
- req0_data  input  16  requester 0 write data
- req0_ready  output  1  requester 0 write accepted this cycle
- req1_valid  input  1  requester 1 has a write pending
- req1_addr  input  4  requester 1 destination register
- req1_data  input  16  requester 1 write data
- req1_ready  output  1  requester 1 write accepted this cycle
- mark_en  input  1  issue stage reserves a destination register
- mark_addr  input  4  register being reserved
- rf_w_en  output  1  to register file w_en
- rf_addr_c  output  4  to register file addr_c
- rf_data_c  output  16  to register file data_c
- busy  output  16  busy[i]=1 while register i has an outstanding write
- last_grant  output  1  id of the most recently accepted requester
- wb_count  output  CNT_W  number of accepted writes, wraps

Behaviour:
- Reset (rst=1 at a clock edge):
  - rf_w_en=0, rf_addr_c=0, rf_data_c=0, busy=0, wb_count=0.
  - last_grant=1, so req0 wins the first contention.
  - req0_ready=req1_ready=0 while rst=1.
  - A write accepted in the cycle before reset is dropped: rf_w_en stays 0 after reset.
- Arbitration (combinational, always ready, no back-pressure from the file):
  - Only req0_valid=1: req0_ready=1.
  - Only req1_valid=1: req1_ready=1.
  - Both valid: the requester other than last_grant gets ready.
  - Never both readies high in the same cycle.
  - Ready may depend on either valid; a requester's valid must not depend on its ready.
  - A transfer occurs when valid&ready at the clock edge.
  - On a transfer, last_grant updates to the accepted id. Otherwise last_grant holds.
- Write stage (latency 1):
  - A transfer at edge N drives rf_w_en=1 with rf_addr_c/rf_data_c equal to the accepted addr/data for exactly the cycle after edge N.
  - With no transfer, rf_w_en=0 and rf_addr_c/rf_data_c hold their previous values.
  - With ZERO_REG_WRITABLE=0 and accepted addr=0: handshake completes, wb_count increments, rf_w_en stays 0.
  - Back-to-back transfers give one write per cycle, full throughput.
- Counter:
  - wb_count increments by 1 on every transfer.
  - Wraps from 2^CNT_W-1 to 0.
- Scoreboard (updates at the clock edge, visible the next cycle):
  - mark_en=1 sets busy[mark_addr].
  - A transfer clears busy[accepted addr].
  - Mark and clear of the same register in the same cycle: mark wins, busy stays 1.
  - Mark and clear of different registers in the same cycle: both apply.
  - Clearing an already-clear bit, or marking an already-set bit, leaves it unchanged.
  - With ZERO_REG_WRITABLE=0, mark_en on addr 0 is ignored.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all valids 0 -> all outputs 0, last_grant=1, both readies 0 throughout.
- Single write: req0_valid=1, addr=5, data=16'hBEEF for one cycle -> req0_ready=1 that cycle; next cycle rf_w_en=1, rf_addr_c=5, rf_data_c=16'hBEEF; cycle after that rf_w_en=0; wb_count=1.
- Contention: both valid continuously for 4 cycles, req0 (addr 1, data 16'h0001) and req1 (addr 2, data 16'h0002) -> grants alternate req0, req1, req0, req1; rf_addr_c sequence 1,2,1,2 with no idle cycle; wb_count=4.
- Scoreboard: mark_en addr 7 -> busy=16'h0080 next cycle; req1 writes addr 7 while mark_en addr 7 in the same cycle -> busy[7] stays 1; a later req1 write to 7 with no mark -> busy=0.
- Zero register (ZERO_REG_WRITABLE=0): mark_en addr 0 -> busy stays 0; req0 write addr 0 -> req0_ready=1, wb_count increments, rf_w_en stays 0.
- Reset mid-operation: transfer at edge N, rst=1 at edge N+1 -> rf_w_en=0 after that edge, busy=0, wb_count=0; counter wrap with CNT_W=2: 4 transfers -> wb_count returns to 0.
